mux_select_sequencer: RTL
=========================

// Module: mux_select_sequencer
// PURPOSE
//  Upstream stage of the 8:1 channel mux. Generates the mux's 3-bit select from a bouncy pushbutton.
//  - Debounces the step pushbutton.
//  - Steps a wrap-around channel index up or down; optionally auto-scans.
//  - Drives the select plus a one-hot channel indicator for LEDs.
// PARAMETERS
//  DEB_CYCLES  500000    clock cycles the key must be stable to be accepted (10 ms @ 50 MHz); >=2
//  SCAN_DIV    50000000  clock cycles per auto-scan step (1 s @ 50 MHz); >=2
// PORTS
//  CLOCK_50   in   1  system clock, rising edge
//  RESET      in   1  asynchronous reset, active-high
//  KEY_STEP   in   1  raw pushbutton, active-low (0 = pressed), asynchronous to CLOCK_50
//  SW_DIR     in   1  0 = step up (+1), 1 = step down (-1); sampled on the step cycle
//  SW_AUTO    in   1  1 = auto-scan enabled (only with SEL_SEQ_AUTO_EN)
//  SEL        out  3  channel select to mux (S[2] = MSB)
//  SEL_ONEHOT out  8  SEL_ONEHOT[i] = (SEL == i)
//  STEP_PULSE out  1  1-cycle pulse in the cycle SEL takes its new value
// BEHAVIOUR
//  Reset (async, any time, mid-debounce or mid-scan):
//   - SEL=0, SEL_ONEHOT=8'h01, STEP_PULSE=0.
//   - Debounce FSM=RELEASED, debounce counter=0, prescaler=0, synchroniser flops=1 (released).
//  Input path: KEY_STEP passes a 2-flop synchroniser -> key_s (2-cycle latency).
//  Debounce FSM (counter cnt):
//   - RELEASED: key_s==0 -> PRESS_WAIT, cnt=0.
//   - PRESS_WAIT: key_s==1 -> RELEASED. cnt==DEB_CYCLES-1 -> PRESSED and raise step request; else cnt++.
//   - PRESSED: key_s==1 -> RELEASE_WAIT, cnt=0.
//   - RELEASE_WAIT: key_s==0 -> PRESSED (no new request). cnt==DEB_CYCLES-1 -> RELEASED; else cnt++.
//   - Exactly one step per accepted press; holding the key never repeats.
//  Step: a request registers SEL <= SEL+1 (SW_DIR=0) or SEL-1 (SW_DIR=1) mod 8. Wrap 7->0 and 0->7.
//  Timing: SEL, SEL_ONEHOT and STEP_PULSE update in the cycle after the FSM enters PRESSED.
//  SEL_ONEHOT is registered, never combinational from SEL; it is always coherent with SEL.
//  Simultaneous manual step and auto tick in one cycle: a single step (+/-1, not 2). Prescaler restarts at 0.
// CONFIGURATION
//  Macro SEL_SEQ_AUTO_EN:
//   Defined:
//    - SCAN_DIV prescaler present. While SW_AUTO=1 it counts 0..SCAN_DIV-1.
//    - At SCAN_DIV-1 it issues an auto step (direction from SW_DIR) and wraps to 0.
//    - SW_AUTO=0 holds the prescaler at 0.
//    - A manual step also clears the prescaler.
//   Undefined:
//    - No prescaler logic. SW_AUTO is ignored (port retained, unused).
//    - SEL changes only on debounced presses.
// STRUCTURE
//  Package sel_seq_pkg:
//   - SEL_W=3, NUM_CH=8.
//   - typedef enum deb_state_t {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
//   - function onehot8(sel).
//  Sub-module key_debouncer:
//   - Ports: clk, rst, key_n_raw, press_pulse.
//   - Contents: synchroniser, FSM, counter, parameter DEB_CYCLES.
//   - Reusable for other KEY inputs.
//  Top: select register, direction logic, one-hot register, prescaler under `ifdef SEL_SEQ_AUTO_EN.
// TESTING (bench uses DEB_CYCLES=4, SCAN_DIV=10, SEL_SEQ_AUTO_EN defined unless stated)
//  1. RESET=1 mid-stream with SEL=5 -> SEL=0, SEL_ONEHOT=8'h01, STEP_PULSE=0 immediately, with no clock edge.
//  2. KEY_STEP low 20 cycles, SW_DIR=0, from SEL=0 -> exactly one STEP_PULSE, SEL=1. Held key gives no further steps.
//  3. Bounce: KEY_STEP toggles every 2 cycles for 12 cycles, then stays high -> no STEP_PULSE, SEL unchanged.
//  4. Wrap: 8 clean presses up from 0 -> SEL sequence 1..7,0. SW_DIR=1 press at SEL=0 -> SEL=7, SEL_ONEHOT=8'h80.
//  5. SW_AUTO=1, SW_DIR=0, no key -> STEP_PULSE every 10 cycles, SEL 0->1->2. Manual step in a tick cycle -> one step only.
//  6. Build without SEL_SEQ_AUTO_EN, SW_AUTO=1 for 100 cycles -> SEL constant, STEP_PULSE never asserted.

Source files
------------

// File: rtl/sel_seq_pkg.sv
// Shared types and helpers for the mux select sequencer and its key debouncer.
package sel_seq_pkg;

  localparam int SEL_W  = 3;
  localparam int NUM_CH = 8;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  function automatic logic [NUM_CH-1:0] onehot8(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Active-low pushbutton debouncer: 2-flop synchroniser, press/release FSM and a
// stability counter. Emits one registered pulse per accepted press.
module key_debouncer
  import sel_seq_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n_raw,
  output logic       press_pulse,
  output deb_state_t state
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          key_s;
  deb_state_t    state_q;
  deb_state_t    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          req;

  // Synchroniser resets to "released" so a reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n_raw};
    end
  end

  assign key_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      press_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_pulse <= req;
    end
  end

  // Any opposite level during a wait state abandons it; only a full stable
  // window commits the transition, and only the press direction requests a step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    case (state_q)
      RELEASED: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          req     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/mux_select_sequencer.sv
// Wrap-around 3-bit channel selector for the 8:1 mux, stepped by a debounced key.
// Define SEL_SEQ_AUTO_EN to add the SW_AUTO-controlled auto-scan prescaler.
module mux_select_sequencer
  import sel_seq_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int SCAN_DIV   = 50000000
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              KEY_STEP,
  input  logic              SW_DIR,
  input  logic              SW_AUTO,
  output logic [SEL_W-1:0]  SEL,
  output logic [NUM_CH-1:0] SEL_ONEHOT,
  output logic              STEP_PULSE
);

  logic             manual_step;
  logic             auto_tick;
  logic             step;
  logic [SEL_W-1:0] sel_next;
  deb_state_t       deb_state;
  logic [1:0]       unused_deb_state;

  key_debouncer #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key_debouncer (
    .clk        (CLOCK_50),
    .rst        (RESET),
    .key_n_raw  (KEY_STEP),
    .press_pulse(manual_step),
    .state      (deb_state)
  );

  assign unused_deb_state = deb_state;

`ifdef SEL_SEQ_AUTO_EN
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q;

  assign auto_tick = SW_AUTO && (presc_q == PRESC_LAST);

  // A manual step restarts the scan period so the next auto step is a full period away.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      presc_q <= '0;
    end else if (!SW_AUTO || manual_step || auto_tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end
`else
  localparam int unused_scan_div = SCAN_DIV;
  logic unused_auto;

  assign unused_auto = SW_AUTO;
  assign auto_tick   = 1'b0;
`endif

  // Manual and auto requests in the same cycle merge into a single step.
  assign step     = manual_step | auto_tick;
  assign sel_next = SW_DIR ? (SEL - SEL_W'(1)) : (SEL + SEL_W'(1));

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      SEL        <= '0;
      SEL_ONEHOT <= onehot8(SEL_W'(0));
      STEP_PULSE <= 1'b0;
    end else begin
      STEP_PULSE <= step;
      if (step) begin
        SEL        <= sel_next;
        SEL_ONEHOT <= onehot8(sel_next);
      end
    end
  end

endmodule
